// File: rtl/hmc_pkg.sv
// Shared HMC definitions: command codes, read predicate,
// and the expected response-beat calculation.
package hmc_pkg;

    typedef enum logic [3:0] {
        CMD_NULL = 4'h0,
        CMD_WR   = 4'h1,
        CMD_PWR  = 4'h2,
        CMD_RD   = 4'h3,
        CMD_MDRD = 4'h4,
        CMD_MDWR = 4'h5
    } hmc_cmd_e;

    function automatic logic is_read(input logic [3:0] c);
        return (c == CMD_RD) || (c == CMD_MDRD);
    endfunction

    // Reads return one beat per FLIT; everything else a single ack.
    // A size of 0 is treated as 1.
    function automatic logic [3:0] exp_beats(
        input logic [3:0] c,
        input logic [3:0] s
    );
        logic [3:0] n;
        n = (s == 4'd0) ? 4'd1 : s;
        return is_read(c) ? n : 4'd1;
    endfunction

endpackage

// File: rtl/hmc_tag_fifo.sv
// Free-tag FIFO: sync, first-word fall-through, depth 2^ID_WIDTH.
// Ports: push/din, pop/dout, full/empty flags.
module hmc_tag_fifo #(
    parameter int ID_WIDTH = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic [ID_WIDTH-1:0] din,
    input  logic                pop,
    output logic [ID_WIDTH-1:0] dout,
    output logic                full,
    output logic                empty
);
    localparam int DEPTH = 1 << ID_WIDTH;
    localparam logic [ID_WIDTH:0] ONE = 1;

    logic [ID_WIDTH-1:0] mem [DEPTH];
    logic [ID_WIDTH:0]   wp;
    logic [ID_WIDTH:0]   rp;
    logic                do_push;
    logic                do_pop;

    // Extra pointer bit distinguishes full from empty.
    assign empty = (wp == rp);
    assign full  = (wp[ID_WIDTH] != rp[ID_WIDTH]) &&
                   (wp[ID_WIDTH-1:0] == rp[ID_WIDTH-1:0]);
    assign dout  = mem[rp[ID_WIDTH-1:0]];

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wp[ID_WIDTH-1:0]] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push)
                wp <= wp + ONE;
            if (do_pop)
                rp <= rp + ONE;
        end
    end

endmodule

// File: rtl/hmc_tag_issuer.sv
// HMC tag issuer: allocates tags to user requests, registers the
// command toward the controller, and recycles tags as responses
// complete. Ports: req_* (user side), cmd_* (controller side),
// rd_data_* (response beats), outstanding count, sticky error flag.
module hmc_tag_issuer
    import hmc_pkg::*;
#(
    parameter int ID_WIDTH   = 6,
    parameter int ADDR_WIDTH = 34
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [3:0]            req_cmd,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [3:0]            req_size,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [3:0]            cmd,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [3:0]            size,
    output logic [ID_WIDTH-1:0]   tag,
    input  logic                  rd_data_valid_in,
    input  logic [ID_WIDTH-1:0]   rd_data_tag_in,
    output logic [ID_WIDTH:0]     outstanding,
    output logic                  err_unexp_tag
);
    localparam int NTAGS = 1 << ID_WIDTH;
    localparam logic [ID_WIDTH:0] ONE = 1;

    logic [ID_WIDTH:0]   fresh_cnt;
    logic                fresh_avail;
    logic [3:0]          beat_cnt;
    logic [NTAGS-1:0]    pending;
    logic [3:0]          exp_mem [NTAGS];

    logic                fifo_full;
    logic                fifo_empty;
    logic [ID_WIDTH-1:0] fifo_dout;

    logic                tag_avail;
    logic                accept;
    logic [ID_WIDTH-1:0] alloc_tag;
    logic                beat_hit;
    logic                rel_beat;

    // Fresh counter saturates at NTAGS, so its MSB marks exhaustion.
    assign fresh_avail = !fresh_cnt[ID_WIDTH];
    assign tag_avail   = fresh_avail || !fifo_empty;
    assign req_ready   = rst_n && tag_avail && (!cmd_valid || cmd_ready);
    assign accept      = req_valid && req_ready;
    assign alloc_tag   = fresh_avail ? fresh_cnt[ID_WIDTH-1:0] : fifo_dout;

    assign beat_hit = rd_data_valid_in && pending[rd_data_tag_in];
    assign rel_beat = beat_hit &&
                      ((beat_cnt + 4'd1) == exp_mem[rd_data_tag_in]);

    hmc_tag_fifo #(
        .ID_WIDTH (ID_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rel_beat),
        .din   (rd_data_tag_in),
        .pop   (accept && !fresh_avail),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (accept)
            exp_mem[alloc_tag] <= exp_beats(req_cmd, req_size);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_valid <= 1'b0;
            cmd       <= '0;
            addr      <= '0;
            size      <= '0;
            tag       <= '0;
        end else if (accept) begin
            cmd_valid <= 1'b1;
            cmd       <= req_cmd;
            addr      <= req_addr;
            size      <= req_size;
            tag       <= alloc_tag;
        end else if (cmd_ready) begin
            cmd_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fresh_cnt <= '0;
        end else if (accept && fresh_avail) begin
            fresh_cnt <= fresh_cnt + ONE;
        end
    end

    // Allocated and released tags are never equal in one cycle:
    // one is pending, the other is not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            if (accept)
                pending[alloc_tag] <= 1'b1;
            if (rel_beat)
                pending[rd_data_tag_in] <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt      <= '0;
            err_unexp_tag <= 1'b0;
        end else if (rd_data_valid_in) begin
            if (!beat_hit)
                err_unexp_tag <= 1'b1;
            else if (rel_beat)
                beat_cnt <= '0;
            else
                beat_cnt <= beat_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else begin
            unique case ({accept, rel_beat})
                2'b10:   outstanding <= outstanding + ONE;
                2'b01:   outstanding <= outstanding - ONE;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // The pending bits guarantee a push never meets a full FIFO.
    always_ff @(posedge clk) begin
        if (rst_n)
            assert (!(rel_beat && fifo_full));
    end

endmodule

// File: tb/tb_hmc_tag_issuer.sv
// Directed bench for hmc_tag_issuer with a command scoreboard.
// Expected commands are queued on acceptance and checked on handshake.
module tb_hmc_tag_issuer;
    import hmc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_cmd;
    logic [33:0] req_addr;
    logic [3:0]  req_size;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd;
    logic [33:0] addr;
    logic [3:0]  size;
    logic [5:0]  tag;
    logic        rd_data_valid_in;
    logic [5:0]  rd_data_tag_in;
    logic [6:0]  outstanding;
    logic        err_unexp_tag;

    typedef struct {
        logic [3:0]  c;
        logic [33:0] a;
        logic [3:0]  s;
        logic [5:0]  t;
    } exp_t;

    exp_t q[$];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    hmc_tag_issuer #(
        .ID_WIDTH   (6),
        .ADDR_WIDTH (34)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_cmd          (req_cmd),
        .req_addr         (req_addr),
        .req_size         (req_size),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd              (cmd),
        .addr             (addr),
        .size             (size),
        .tag              (tag),
        .rd_data_valid_in (rd_data_valid_in),
        .rd_data_tag_in   (rd_data_tag_in),
        .outstanding      (outstanding),
        .err_unexp_tag    (err_unexp_tag)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a handshake happens at the posedge following this sample.
    always @(negedge clk) begin : monitor
        exp_t e;
        #2;
        if (rst_n && cmd_valid && cmd_ready) begin
            if (q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL spurious_cmd: got tag %0d, expected none", tag);
            end else begin
                e = q.pop_front();
                chk("sb_cmd", cmd, e.c);
                chk("sb_addr", addr, e.a);
                chk("sb_size", size, e.s);
                chk("sb_tag", tag, e.t);
            end
        end
    end

    task automatic issue(input logic [3:0] c, input logic [33:0] a,
                         input logic [3:0] s, input logic [5:0] et);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_cmd   = c;
        req_addr  = a;
        req_size  = s;
        #1;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!req_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL issue_timeout tag %0d: req_ready got 0, expected 1", et);
            req_valid = 1'b0;
            return;
        end
        q.push_back('{c, a, s, et});
        @(negedge clk);
        req_valid = 1'b0;
        chk("valid_tag_after_accept", {cmd_valid, tag}, {1'b1, et});
    endtask

    task automatic beat(input logic [5:0] t);
        rd_data_valid_in = 1'b1;
        rd_data_tag_in   = t;
        @(negedge clk);
        rd_data_valid_in = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n            = 1'b0;
        req_valid        = 1'b0;
        req_cmd          = '0;
        req_addr         = '0;
        req_size         = '0;
        cmd_ready        = 1'b1;
        rd_data_valid_in = 1'b0;
        rd_data_tag_in   = '0;

        // Reset values
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_err", err_unexp_tag, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Three back-to-back reads
        issue(CMD_RD, 34'h100, 4'd4, 6'd0);
        issue(CMD_RD, 34'h200, 4'd4, 6'd1);
        issue(CMD_RD, 34'h300, 4'd4, 6'd2);
        chk("outstanding_3", outstanding, 3);
        @(negedge clk);

        // Controller stall
        cmd_ready = 1'b0;
        issue(CMD_WR, 34'h3C0, 4'd1, 6'd3);
        req_valid = 1'b1;
        req_cmd   = CMD_WR;
        req_addr  = 34'h400;
        req_size  = 4'd2;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_req_ready", req_ready, 0);
            chk("stall_tag", tag, 3);
            chk("stall_addr", addr, 34'h3C0);
            @(negedge clk);
        end
        cmd_ready = 1'b1;
        #1;
        chk("unstall_req_ready", req_ready, 1);
        q.push_back('{CMD_WR, 34'h400, 4'd2, 6'd4});
        @(negedge clk);
        req_valid = 1'b0;
        chk("unstall_next_tag", {cmd_valid, tag}, {1'b1, 6'd4});
        chk("outstanding_5", outstanding, 5);

        // 8-beat read on tag 5
        issue(CMD_RD, 34'h500, 4'd8, 6'd5);
        @(negedge clk);
        chk("outstanding_6", outstanding, 6);
        for (int k = 1; k <= 8; k++) begin
            beat(6'd5);
            chk("burst_outstanding", outstanding, (k < 8) ? 6 : 5);
        end

        // Ten outstanding, then reset mid-operation
        for (int i = 6; i <= 10; i++)
            issue(CMD_WR, 34'(i) * 34'h40, 4'd1, 6'(i));
        chk("outstanding_10", outstanding, 10);
        @(negedge clk);
        #5;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cmd_valid", cmd_valid, 0);
        chk("mid_rst_tag", tag, 0);
        chk("mid_rst_addr", addr, 0);
        chk("mid_rst_outstanding", outstanding, 0);
        chk("mid_rst_req_ready", req_ready, 0);
        q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Beat for a tag never issued
        beat(6'd40);
        chk("unexp_err", err_unexp_tag, 1);
        chk("unexp_outstanding", outstanding, 0);
        repeat (3) @(negedge clk);
        chk("unexp_err_sticky", err_unexp_tag, 1);

        // Exhaust all 64 tags, tags restart at 0
        for (int i = 0; i < 64; i++)
            issue(CMD_WR, 34'(i) * 34'h40, 4'd1, 6'(i));
        @(negedge clk);
        chk("full_req_ready", req_ready, 0);
        chk("full_outstanding", outstanding, 64);
        beat(6'd17);
        chk("rel17_outstanding", outstanding, 63);
        chk("rel17_req_ready", req_ready, 1);
        issue(CMD_WR, 34'h1234, 4'd1, 6'd17);
        chk("reissue_outstanding", outstanding, 64);

        // Simultaneous pop and push
        beat(6'd20);
        beat(6'd21);
        chk("rel2_outstanding", outstanding, 62);
        rd_data_valid_in = 1'b1;
        rd_data_tag_in   = 6'd22;
        issue(CMD_RD, 34'h2000, 4'd2, 6'd20);
        rd_data_valid_in = 1'b0;
        chk("popush_outstanding", outstanding, 62);
        issue(CMD_WR, 34'h2100, 4'd1, 6'd21);
        issue(CMD_WR, 34'h2200, 4'd1, 6'd22);
        chk("refill_outstanding", outstanding, 64);
        chk("refill_req_ready", req_ready, 0);
        chk("err_still_set", err_unexp_tag, 1);

        repeat (3) @(negedge clk);
        chk("sb_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hmc_tag_issuer.md
HMC_TAG_ISSUER -- requirements
Module: hmc_tag_issuer

Interface
REQ-001 Parameters SHALL be: ID_WIDTH, default 6, tag width (2^ID_WIDTH tags); ADDR_WIDTH, default 34, HMC byte address width.
REQ-002 Ports SHALL be:
- clk  in  1  sole clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  user request valid
- req_ready  out  1  user request accepted when valid and ready
- req_cmd  in  4  HMC command code
- req_addr  in  ADDR_WIDTH  request address
- req_size  in  4  request size field, 1..8 FLITs
- cmd_valid  out  1  command to HMC controller valid
- cmd_ready  in  1  controller accepts the command
- cmd  out  4  registered req_cmd
- addr  out  ADDR_WIDTH  registered req_addr
- size  out  4  registered req_size
- tag  out  ID_WIDTH  allocated tag
- rd_data_valid_in  in  1  response beat valid (same bus seen by the response reorder block)
- rd_data_tag_in  in  ID_WIDTH  response beat tag
- outstanding  out  ID_WIDTH+1  count of issued, unreleased tags
- err_unexp_tag  out  1  sticky: beat arrived for a tag not outstanding

Function
REQ-003 Expected response beats SHALL be: req_size when req_cmd is a read code, otherwise 1; a req_size of 0 SHALL be treated as 1.
REQ-004 Tag source SHALL be a fresh counter while fresh_cnt < 2^ID_WIDTH (tags 0,1,2,... in order), then pops from the free-tag FIFO (depth 2^ID_WIDTH).
REQ-005 tag_avail SHALL be (fresh_cnt < 2^ID_WIDTH) or (free FIFO not empty), registered state only, with no same-cycle bypass from a release.
REQ-006 req_ready SHALL be tag_avail and (not cmd_valid or cmd_ready); it is combinational from registered state and cmd_ready.
REQ-007 On req_valid and req_ready: cmd, addr, size, and tag load on the next edge; cmd_valid SHALL be 1; latency is exactly 1 cycle.
REQ-008 The expected beat count and the pending bit for the allocated tag SHALL be written in the same cycle as the acceptance.
REQ-009 While cmd_valid=1 and cmd_ready=0, all cmd outputs SHALL hold stable.
REQ-010 cmd_valid SHALL clear after a cmd_ready handshake unless a new request is accepted in the same cycle (back-to-back issue at 1 per cycle).
REQ-011 Beats of one response are contiguous; beat_cnt SHALL count beats of the current response.
- On a beat where beat_cnt+1 equals the expected count for that tag: release the tag (push to the free FIFO, clear its pending bit) and reset beat_cnt to 0.
- Otherwise: increment beat_cnt.
REQ-012 A beat whose tag pending bit is 0 SHALL set err_unexp_tag, be otherwise ignored, and not push to the FIFO.
REQ-013 outstanding SHALL increment on acceptance and decrement on release; when both occur in the same cycle it is unchanged. Range is 0..2^ID_WIDTH.
REQ-014 When 2^ID_WIDTH tags are outstanding: req_ready=0. The first release makes req_ready=1 on the following cycle.
REQ-015 On allocate and release in the same cycle, the FIFO SHALL pop and push simultaneously without loss. A full FIFO cannot receive a push (the invariant is guaranteed by the pending bit).
REQ-016 Fresh tag wrap: fresh_cnt SHALL saturate at 2^ID_WIDTH and never re-issue fresh tags.

Reset
REQ-017 With rst_n low, the following SHALL be asynchronously cleared:
- cmd_valid=0, cmd/addr/size/tag=0
- req_ready=0 while in reset
- outstanding=0, err_unexp_tag=0
- fresh_cnt=0, beat_cnt=0, FIFO pointers=0, all pending bits=0
REQ-018 Beat-count storage and FIFO storage SHALL be non-reset memory. A reset mid-operation abandons all outstanding tags; beats arriving after reset flag err_unexp_tag.

Structure
REQ-019 The shared HMC package SHALL hold the command codes, the read-code predicate, and the function computing expected response beats. The response reorder block uses the same function.
REQ-020 The free-tag FIFO SHALL be one sub-module, hmc_tag_fifo (sync, width ID_WIDTH, depth 2^ID_WIDTH, with full and empty flags).

Verification
REQ-021 Reset, then 3 back-to-back reads with cmd_ready=1 -> tags 0,1,2 on consecutive cycles, each 1 cycle after acceptance, outstanding=3.
REQ-022 cmd_ready=0 for 5 cycles with a command pending -> cmd/tag stable, req_ready=0; then cmd_ready=1 -> handshake and next request accepted in the same cycle.
REQ-023 Issue 64 writes without responses -> req_ready=0, outstanding=64. Return a 1-beat response for tag 17 -> the next request gets tag 17 one cycle after the release.
REQ-024 Read size 8 on tag 5, return 8 beats -> release only on the 8th beat; outstanding decrements by 1 at that beat.
REQ-025 Beat with tag 40 never issued -> err_unexp_tag=1 and stays 1; outstanding unchanged.
REQ-026 Assert rst_n=0 with 10 tags outstanding -> all outputs go to reset values immediately; after release, tags restart at 0.
